// File: rtl/lc3b_mem_responder.sv
// LC-3b style memory responder: single outstanding request, fixed completion
// latency, byte-lane writes and a registered read-data port.
module lc3b_mem_responder #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   cap_idx;
    logic [15:0]             cap_wdata;
    logic [1:0]              cap_be;
    logic                    cap_write;

    logic [15:0]             mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   t_idx;
    logic [15:0]             t_wdata;
    logic [1:0]              t_be;
    logic                    t_write;
    logic                    go_resp;
    logic                    addr_unused;

    // Byte bit and upper address bits only alias into the word index.
    assign addr_unused = ^mem_address;

    // Live transaction view: raw inputs on the accepting edge, captured copy afterwards.
    always_comb begin
        t_idx   = cap_idx;
        t_wdata = cap_wdata;
        t_be    = cap_be;
        t_write = cap_write;
        go_resp = 1'b0;
        case (state)
            IDLE: begin
                t_idx   = mem_address[ADDR_WIDTH:1];
                t_wdata = mem_wdata;
                t_be    = mem_byte_enable;
                t_write = mem_write;
                go_resp = (mem_read || mem_write) && (LATENCY == 1);
            end
            BUSY:    go_resp = (cnt == CNT_W'(1));
            default: go_resp = 1'b0;
        endcase
    end

    // Control FSM with registered response, read data and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_resp  <= 1'b0;
            proto_err <= 1'b0;
            mem_rdata <= '0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            cap_write <= 1'b0;
        end else begin
            mem_resp  <= go_resp;
            proto_err <= 1'b0;
            if (go_resp && !t_write) begin
                mem_rdata <= mem[t_idx];
            end
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        cap_idx   <= t_idx;
                        cap_wdata <= t_wdata;
                        cap_be    <= t_be;
                        cap_write <= t_write;
                        cnt       <= CNT_W'(LATENCY - 1);
                        proto_err <= mem_read && mem_write;
                        state     <= go_resp ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (go_resp) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Storage survives reset; only the commit is suppressed by it.
    always_ff @(posedge clk) begin
        if (!reset && go_resp && t_write) begin
            if (t_be[0]) begin
                mem[t_idx][7:0] <= t_wdata[7:0];
            end
            if (t_be[1]) begin
                mem[t_idx][15:8] <= t_wdata[15:8];
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench: instance 0 runs with LATENCY=3, instance 1 with LATENCY=1.
module tb_lc3b_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd    [2];
    logic        wr    [2];
    logic [1:0]  be    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic [15:0] rdata [2];
    logic        resp  [2];
    logic        perr  [2];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          id;
        int          cyc;
        logic [15:0] rdata;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } pe_t;

    exp_t exp_q[$];
    pe_t  pe_q[$];
    exp_t me;
    pe_t  mp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lc3b_mem_responder #(
            .LATENCY   ((g == 0) ? 3 : 1),
            .ADDR_WIDTH(8)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .mem_read       (rd[g]),
            .mem_write      (wr[g]),
            .mem_byte_enable(be[g]),
            .mem_address    (addr[g]),
            .mem_wdata      (wdata[g]),
            .mem_rdata      (rdata[g]),
            .mem_resp       (resp[g]),
            .proto_err      (perr[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response / error pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (resp[d]) begin
                    if (exp_q.size() == 0 || exp_q[0].id != d) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_resp: dut %0d pulsed mem_resp in cycle %0d, none required", d, cyc);
                    end else begin
                        me = exp_q.pop_front();
                        chk($sformatf("resp_cycle_dut%0d", d), 32'(cyc), 32'(me.cyc));
                        chk($sformatf("rdata_dut%0d_cyc%0d", d, cyc), 32'(rdata[d]), 32'(me.rdata));
                    end
                end
                if (perr[d]) begin
                    if (pe_q.size() == 0 || pe_q[0].id != d) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_proto_err: dut %0d in cycle %0d, none required", d, cyc);
                    end else begin
                        mp = pe_q.pop_front();
                        chk($sformatf("proto_err_cycle_dut%0d", d), 32'(cyc), 32'(mp.cyc));
                    end
                end
            end
        end
    end

    // Issue one request, push expectations, scramble inputs while busy, wait for completion.
    task automatic txn(input int d, input logic r, input logic w, input logic [1:0] b,
                       input logic [15:0] a, input logic [15:0] wd, input logic [15:0] exp_rd);
        exp_t e;
        pe_t  p;
        int   n;
        rd[d] = r; wr[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        e.id = d; e.cyc = cyc + lat_of(d); e.rdata = exp_rd;
        exp_q.push_back(e);
        if (r && w) begin
            p.id = d; p.cyc = cyc + 1;
            pe_q.push_back(p);
        end
        @(posedge clk); #1;
        addr[d] = a ^ 16'h00FE; wdata[d] = ~wd; be[d] = ~b;
        @(negedge clk);
        n = 0;
        while (!resp[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!resp[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: dut %0d addr %h no mem_resp within bound", d, a);
        end
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; be[d] = 2'b00; addr[d] = '0; wdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_resp_dut%0d", d),  32'(resp[d]),  32'd0);
            chk($sformatf("reset_perr_dut%0d", d),  32'(perr[d]),  32'd0);
            chk($sformatf("reset_rdata_dut%0d", d), 32'(rdata[d]), 32'h0000);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // LATENCY=3 instance
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF);
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, 16'hBEEF);
        txn(0, 1'b0, 1'b1, 2'b01, 16'h0020, 16'hABCD, 16'hBEEF);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h12CD);
        txn(0, 1'b0, 1'b1, 2'b10, 16'h0020, 16'hABCD, 16'h12CD);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'hABCD);
        txn(0, 1'b1, 1'b1, 2'b11, 16'h0030, 16'h5555, 16'hABCD);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h5555);
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'h0000, 16'h5555);
        txn(0, 1'b0, 1'b1, 2'b00, 16'h0040, 16'hFFFF, 16'h5555);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h0000);

        // Reset in the cycle after acceptance aborts the write without a response
        wr[0] = 1'b1; be[0] = 2'b11; addr[0] = 16'h0040; wdata[0] = 16'h9999;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; wr[0] = 1'b0;
        chk("abort_resp",  32'(resp[0]),  32'd0);
        chk("abort_perr",  32'(perr[0]),  32'd0);
        chk("abort_rdata", 32'(rdata[0]), 32'h0000);
        repeat (6) @(posedge clk);
        #1;

        txn(0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h0000);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF);
        txn(0, 1'b0, 1'b1, 2'b11, 16'h0202, 16'h7777, 16'hBEEF);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, 16'h7777);
        txn(0, 1'b1, 1'b0, 2'b00, 16'h0003, 16'h0000, 16'h7777);

        // LATENCY=1 instance, back-to-back with no idle gap
        txn(1, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hCAFE, 16'h0000);
        txn(1, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hCAFE);
        txn(1, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hCAFE);
        txn(1, 1'b0, 1'b1, 2'b11, 16'h0012, 16'h1111, 16'hCAFE);
        txn(1, 1'b1, 1'b1, 2'b11, 16'h0012, 16'h2222, 16'hCAFE);
        txn(1, 1'b1, 1'b0, 2'b00, 16'h0012, 16'h0000, 16'h2222);

        repeat (4) @(posedge clk);
        #1;
        chk("leftover_resp_expectations", 32'(exp_q.size()), 32'd0);
        chk("leftover_proto_expectations", 32'(pe_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
